ifetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath. It owns the program counter and issues in-order word requests to a variable-latency instruction memory. Returned instructions are buffered with their PCs in a small queue and presented to the datapath over a valid/ready handshake. A redirect (branch/jump) flushes the queue and discards responses still in flight.

---
 rtl/ifetch_pkg.sv | 11 +
 rtl/ifetch_if.sv | 35 +++
 rtl/ifetch_queue.sv | 61 ++++++
 rtl/ifetch_unit.sv | 104 ++++++++++
 tb/tb_ifetch_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int PC_INC = 4;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction memory request/response, redirect and datapath handshake.
interface ifetch_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);

  logic             imem_req_valid;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_req_ready;
  logic             imem_rsp_valid;
  logic [INS_W-1:0] imem_rsp_data;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             out_valid;
  logic [INS_W-1:0] out_instr;
  logic [PC_W-1:0]  out_pc;
  logic             out_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/ifetch_queue.sv
// Synchronous FIFO holding {pc, instr} pairs; the fetch credit rule keeps it from overflowing.
module ifetch_queue #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues in-order word requests under a credit limit, queues responses.
//   state | meaning
//   RUN   | issuing requests, responses are pushed into the queue
//   DRAIN | discarding responses of requests issued before a redirect
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      reset,
  ifetch_if.master bus
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]  CREDITS = (CNT_W+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0]       q_count;
  logic [PC_W+INS_W-1:0]  q_head;
  logic [CNT_W:0]         in_use;
  logic                   req_valid, req_fire, rsp_push, out_pop;
  logic [PC_W-1:0]        redir_pc;

  // Queue slots plus in-flight requests never exceed DEPTH, so every response has a home.
  assign in_use    = {1'b0, q_count} + {1'b0, outst_q};
  assign req_valid = !reset && (state_q == RUN) && !bus.redirect_valid && (in_use < CREDITS);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign rsp_push  = bus.imem_rsp_valid && (state_q == RUN) && !bus.redirect_valid;
  assign out_pop   = bus.out_valid && bus.out_ready;
  assign redir_pc  = bus.redirect_pc & ~PC_W'(3);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    unique case ({req_fire, bus.imem_rsp_valid})
      2'b10:   outst_d = outst_q + ONE;
      2'b01:   outst_d = outst_q - ONE;
      default: outst_d = outst_q;
    endcase
    if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (rsp_push) rsp_pc_d = rsp_pc_q + PC_STEP;
    if (state_q == DRAIN) begin
      if (bus.imem_rsp_valid) drop_d = drop_q - ONE;
      state_d = (drop_d == '0) ? RUN : DRAIN;
    end
    if (bus.redirect_valid) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      // No request fires during a redirect, so outst_d already excludes the dropped response.
      if (state_q == RUN) drop_d = outst_d;
      state_d = (drop_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  ifetch_queue #(
    .W     (PC_W + INS_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_push),
    .data_i  ({rsp_pc_q, bus.imem_rsp_data}),
    .pop_i   (out_pop),
    .flush_i (bus.redirect_valid),
    .data_o  (q_head),
    .count_o (q_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = (q_count != '0);
  assign bus.out_pc         = q_head[PC_W+INS_W-1:INS_W];
  assign bus.out_instr      = q_head[INS_W-1:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a cycle table plus memory-model sequences with a PC scoreboard.
module tb_ifetch_unit;

  localparam logic [8:0] RESET_PC = 9'h000;
  localparam int NV = 26;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        rdir;
    logic [8:0]  rpc;
    logic        ordy;
    logic        e_req;
    logic [8:0]  e_addr;
    logic        e_ov;
    logic [8:0]  e_pc;
    logic [31:0] e_ins;
  } vec_t;

  typedef struct {
    logic [8:0] addr;
    int         due;
  } mreq_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifetch_if #(.PC_W(9), .INS_W(32)) bus ();

  ifetch_unit #(
    .PC_W     (9),
    .INS_W    (32),
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  logic g_rdy = 1'b1;
  logic g_ordy = 1'b1;
  mreq_t memq[$];
  logic [8:0] exp_pc = RESET_PC;
  int n_req = 0;
  int n_pop = 0;
  logic s_req, s_ov;
  logic [8:0] s_addr;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [8:0] a);
    return 32'hA500_0000 | {23'd0, a};
  endfunction

  function automatic vec_t v(input logic rdy, input logic rsp, input logic [31:0] data,
                             input logic rdir, input logic [8:0] rpc, input logic ordy,
                             input logic e_req, input logic [8:0] e_addr, input logic e_ov,
                             input logic [8:0] e_pc, input logic [31:0] e_ins);
    vec_t r;
    r.rdy = rdy; r.rsp = rsp; r.data = data; r.rdir = rdir; r.rpc = rpc; r.ordy = ordy;
    r.e_req = e_req; r.e_addr = e_addr; r.e_ov = e_ov; r.e_pc = e_pc; r.e_ins = e_ins;
    return r;
  endfunction

  // One cycle against the memory model; inputs change and outputs are sampled mid-low-phase.
  task automatic step(input logic rst, input logic rdir, input logic [8:0] rpc);
    reset = rst;
    bus.imem_req_ready = g_rdy;
    bus.out_ready = g_ordy;
    bus.redirect_valid = rdir;
    bus.redirect_pc = rpc;
    if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = mdata(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = '0;
    end
    #1;
    s_req = bus.imem_req_valid;
    s_addr = bus.imem_req_addr;
    s_ov = bus.out_valid;
    if (rst) begin
      memq.delete();
      exp_pc = RESET_PC;
      n_req = 0;
      n_pop = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("sb pc #%0d", n_pop), {23'd0, bus.out_pc}, {23'd0, exp_pc});
        chk($sformatf("sb instr #%0d", n_pop), bus.out_instr, mdata(exp_pc));
        exp_pc = exp_pc + 9'd4;
        n_pop++;
      end
      if (rdir) exp_pc = {rpc[8:2], 2'b00};
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        memq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
        n_req++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 9'h0);
    step(1'b1, 1'b0, 9'h0);
    chk("reset req_valid", {31'd0, s_req}, 32'd0);
    chk("reset out_valid", {31'd0, s_ov}, 32'd0);
  endtask

  initial begin
    //           rdy rsp data          rdir rpc     ordy  e_req e_addr  e_ov e_pc    e_ins
    vecs[0]  = v(1, 0, 32'h0,         0, 9'h000, 1,   1, 9'h000, 0, 9'h000, 32'h0);
    vecs[1]  = v(1, 1, 32'hD000_0000, 0, 9'h000, 1,   1, 9'h004, 0, 9'h000, 32'h0);
    vecs[2]  = v(1, 1, 32'hD000_0001, 0, 9'h000, 1,   1, 9'h008, 1, 9'h000, 32'hD000_0000);
    vecs[3]  = v(0, 1, 32'hD000_0002, 0, 9'h000, 0,   1, 9'h00C, 1, 9'h004, 32'hD000_0001);
    vecs[4]  = v(1, 0, 32'h0,         0, 9'h000, 0,   1, 9'h00C, 1, 9'h004, 32'hD000_0001);
    vecs[5]  = v(1, 0, 32'h0,         0, 9'h000, 0,   1, 9'h010, 1, 9'h004, 32'hD000_0001);
    vecs[6]  = v(1, 0, 32'h0,         0, 9'h000, 0,   0, 9'h000, 1, 9'h004, 32'hD000_0001);
    vecs[7]  = v(1, 1, 32'hD000_0003, 0, 9'h000, 0,   0, 9'h000, 1, 9'h004, 32'hD000_0001);
    vecs[8]  = v(1, 0, 32'h0,         0, 9'h000, 1,   0, 9'h000, 1, 9'h004, 32'hD000_0001);
    vecs[9]  = v(1, 0, 32'h0,         1, 9'h043, 1,   0, 9'h000, 1, 9'h008, 32'hD000_0002);
    vecs[10] = v(1, 0, 32'h0,         0, 9'h000, 1,   0, 9'h000, 0, 9'h000, 32'h0);
    vecs[11] = v(1, 1, 32'hD000_0004, 0, 9'h000, 1,   0, 9'h000, 0, 9'h000, 32'h0);
    vecs[12] = v(1, 0, 32'h0,         0, 9'h000, 1,   1, 9'h040, 0, 9'h000, 32'h0);
    vecs[13] = v(1, 1, 32'hE000_0000, 0, 9'h000, 0,   1, 9'h044, 0, 9'h000, 32'h0);
    vecs[14] = v(0, 0, 32'h0,         0, 9'h000, 1,   1, 9'h048, 1, 9'h040, 32'hE000_0000);
    vecs[15] = v(1, 1, 32'hE000_0001, 0, 9'h000, 0,   1, 9'h048, 0, 9'h000, 32'h0);
    vecs[16] = v(1, 0, 32'h0,         0, 9'h000, 0,   1, 9'h04C, 1, 9'h044, 32'hE000_0001);
    vecs[17] = v(0, 1, 32'hE000_0002, 1, 9'h1F8, 1,   0, 9'h000, 1, 9'h044, 32'hE000_0001);
    vecs[18] = v(1, 0, 32'h0,         0, 9'h000, 1,   0, 9'h000, 0, 9'h000, 32'h0);
    vecs[19] = v(1, 1, 32'hE000_0003, 0, 9'h000, 1,   0, 9'h000, 0, 9'h000, 32'h0);
    vecs[20] = v(1, 0, 32'h0,         0, 9'h000, 1,   1, 9'h1F8, 0, 9'h000, 32'h0);
    vecs[21] = v(1, 1, 32'hF000_0000, 0, 9'h000, 1,   1, 9'h1FC, 0, 9'h000, 32'h0);
    vecs[22] = v(1, 1, 32'hF000_0001, 0, 9'h000, 1,   1, 9'h000, 1, 9'h1F8, 32'hF000_0000);
    vecs[23] = v(0, 1, 32'hF000_0002, 0, 9'h000, 1,   1, 9'h004, 1, 9'h1FC, 32'hF000_0001);
    vecs[24] = v(0, 0, 32'h0,         0, 9'h000, 1,   1, 9'h004, 1, 9'h000, 32'hF000_0002);
    vecs[25] = v(0, 0, 32'h0,         0, 9'h000, 1,   1, 9'h004, 0, 9'h000, 32'h0);

    // Cycle table: streaming, backpressure, redirect with drain, coincident redirect, PC wrap.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      reset = 1'b0;
      bus.imem_req_ready = vecs[i].rdy;
      bus.imem_rsp_valid = vecs[i].rsp;
      bus.imem_rsp_data = vecs[i].data;
      bus.redirect_valid = vecs[i].rdir;
      bus.redirect_pc = vecs[i].rpc;
      bus.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d req_valid", i), {31'd0, bus.imem_req_valid}, {31'd0, vecs[i].e_req});
      if (vecs[i].e_req)
        chk($sformatf("vec%0d req_addr", i), {23'd0, bus.imem_req_addr}, {23'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d out_pc", i), {23'd0, bus.out_pc}, {23'd0, vecs[i].e_pc});
        chk($sformatf("vec%0d out_instr", i), bus.out_instr, vecs[i].e_ins);
      end
      @(negedge clk);
      cyc++;
    end

    // Streaming with 1-cycle memory: one instruction per cycle once the pipe fills.
    lat = 1; g_rdy = 1'b1; g_ordy = 1'b1;
    do_reset();
    step(1'b0, 1'b0, 9'h0);
    chk("A first req_valid", {31'd0, s_req}, 32'd1);
    chk("A first req_addr", {23'd0, s_addr}, {23'd0, RESET_PC});
    repeat (19) step(1'b0, 1'b0, 9'h0);
    chk("A pops", n_pop, 18);

    // Consumer stalled with 4-cycle memory: credits cap in-flight work at DEPTH.
    lat = 4; g_ordy = 1'b0;
    do_reset();
    repeat (12) step(1'b0, 1'b0, 9'h0);
    chk("B requests", n_req, 4);
    chk("B req_valid held", {31'd0, s_req}, 32'd0);
    chk("B out_valid", {31'd0, s_ov}, 32'd1);
    g_ordy = 1'b1;
    repeat (30) step(1'b0, 1'b0, 9'h0);
    chk("B pops", {31'd0, n_pop >= 12}, 32'd1);
    chk("B in flight", {31'd0, (n_req - n_pop) <= 4}, 32'd1);

    // Redirect with three requests outstanding: drain three stale responses, restart at 0x040.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 9'h0);
    step(1'b0, 1'b1, 9'h043);
    chk("C1 redirect req_valid", {31'd0, s_req}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 9'h0);
      chk($sformatf("C1 drain%0d req_valid", k), {31'd0, s_req}, 32'd0);
      chk($sformatf("C1 drain%0d out_valid", k), {31'd0, s_ov}, 32'd0);
    end
    step(1'b0, 1'b0, 9'h0);
    chk("C1 restart req_valid", {31'd0, s_req}, 32'd1);
    chk("C1 restart req_addr", {23'd0, s_addr}, 32'h040);
    repeat (12) step(1'b0, 1'b0, 9'h0);
    chk("C1 pops", {31'd0, n_pop >= 3}, 32'd1);

    // Second redirect while draining only reloads the PCs.
    do_reset();
    repeat (3) step(1'b0, 1'b0, 9'h0);
    step(1'b0, 1'b1, 9'h043);
    step(1'b0, 1'b0, 9'h0);
    step(1'b0, 1'b1, 9'h081);
    chk("C2 drain redirect req_valid", {31'd0, s_req}, 32'd0);
    step(1'b0, 1'b0, 9'h0);
    chk("C2 last drop req_valid", {31'd0, s_req}, 32'd0);
    step(1'b0, 1'b0, 9'h0);
    chk("C2 restart req_valid", {31'd0, s_req}, 32'd1);
    chk("C2 restart req_addr", {23'd0, s_addr}, 32'h080);
    repeat (12) step(1'b0, 1'b0, 9'h0);
    chk("C2 pops", {31'd0, n_pop >= 3}, 32'd1);

    // Reset with two responses queued and two requests in flight.
    lat = 4; g_ordy = 1'b0;
    do_reset();
    repeat (6) step(1'b0, 1'b0, 9'h0);
    chk("D queued before reset", {31'd0, s_ov}, 32'd1);
    step(1'b1, 1'b0, 9'h0);
    chk("D reset req_valid", {31'd0, s_req}, 32'd0);
    lat = 10;
    step(1'b0, 1'b0, 9'h0);
    chk("D post-reset out_valid", {31'd0, s_ov}, 32'd0);
    chk("D post-reset req_valid", {31'd0, s_req}, 32'd1);
    chk("D post-reset req_addr", {23'd0, s_addr}, {23'd0, RESET_PC});
    repeat (5) step(1'b0, 1'b0, 9'h0);
    chk("D full credits", n_req, 4);
    chk("D out_valid idle", {31'd0, s_ov}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
